// File: rtl/uart_loader.sv
// UART boot loader: receives 0xA5-headed frames of little-endian 32-bit words, writes
// them to word-addressed memory, and answers 0x4B on a good checksum or 0x45 otherwise.
module uart_loader #(
    parameter logic [15:0] PERIOD = 16'd2604
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] BIT_LAST  = PERIOD - 16'd1;
    localparam logic [15:0] HALF_LAST = (PERIOD / 16'd2) - 16'd1;
    localparam logic [7:0]  HEADER    = 8'hA5;
    localparam logic [7:0]  RSP_OK    = 8'h4B;
    localparam logic [7:0]  RSP_BAD   = 8'h45;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {HUNT, ADDR, CNT, DATA, SUM, RESP} fr_state_e;

    logic rxd_s1_q, rxd_s2_q;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_timer_q, rx_timer_d;
    logic [2:0]  rx_bit_q,   rx_bit_d;
    logic [7:0]  rx_byte_q,  rx_byte_d;
    logic        rx_valid,   rx_ferr;

    fr_state_e   fr_state_q, fr_state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [29:0] base_q,     base_d;
    logic [23:0] word_q,     word_d;
    logic [7:0]  csum_q,     csum_d;
    logic        mem_we_q,   mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;

    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_active_q, tx_active_d;
    logic [15:0] tx_timer_q,  tx_timer_d;
    logic [3:0]  tx_bit_q,    tx_bit_d;
    logic [9:0]  tx_shift_q,  tx_shift_d;
    logic        tx_done;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= R_IDLE;
            rx_timer_q <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_byte_q  <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        case (rx_state_q)
            R_IDLE: begin
                if (!rxd_s2_q) begin
                    rx_state_d = R_START;
                    rx_timer_d = 16'd0;
                end
            end
            R_START: begin
                if (rx_timer_q == HALF_LAST) begin
                    rx_timer_d = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rxd_s2_q ? R_IDLE : R_DATA;
                end else begin
                    rx_timer_d = rx_timer_q + 16'd1;
                end
            end
            R_DATA: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = 16'd0;
                    rx_byte_d  = {rxd_s2_q, rx_byte_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + 16'd1;
                end
            end
            R_STOP: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = 16'd0;
                    rx_state_d = R_IDLE;
                end else begin
                    rx_timer_d = rx_timer_q + 16'd1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rx_valid = (rx_state_q == R_STOP) && (rx_timer_q == BIT_LAST) &&  rxd_s2_q;
        rx_ferr  = (rx_state_q == R_STOP) && (rx_timer_q == BIT_LAST) && !rxd_s2_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fr_state_q  <= HUNT;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= 16'd0;
            cnt_q       <= 16'd0;
            base_q      <= 30'd0;
            word_q      <= 24'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'd0;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fr_state_q  <= fr_state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        fr_state_d  = fr_state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if ((fr_state_q == RESP) && tx_done) begin
            fr_state_d = HUNT;
        end
        if (rx_ferr) begin
            err_d      = 1'b1;
            fr_state_d = HUNT;
        end else if (rx_valid) begin
            case (fr_state_q)
                HUNT: begin
                    if (rx_byte_q == HEADER) begin
                        fr_state_d = ADDR;
                        csum_d     = 8'd0;
                        byte_cnt_d = 2'd0;
                    end
                end
                ADDR: begin
                    // Only the word-address bits [31:2] of the base are kept.
                    csum_d     = csum_q ^ rx_byte_q;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    base_d[5:0]   = rx_byte_q[7:2];
                        2'd1:    base_d[13:6]  = rx_byte_q;
                        2'd2:    base_d[21:14] = rx_byte_q;
                        default: base_d[29:22] = rx_byte_q;
                    endcase
                    if (byte_cnt_q == 2'd3) begin
                        fr_state_d = CNT;
                    end
                end
                CNT: begin
                    csum_d = csum_q ^ rx_byte_q;
                    if (byte_cnt_q == 2'd0) begin
                        cnt_d[7:0] = rx_byte_q;
                        byte_cnt_d = 2'd1;
                    end else begin
                        cnt_d[15:8] = rx_byte_q;
                        byte_cnt_d  = 2'd0;
                        word_cnt_d  = 16'd0;
                        fr_state_d  = ({rx_byte_q, cnt_q[7:0]} != 16'd0) ? DATA : SUM;
                    end
                end
                DATA: begin
                    csum_d     = csum_q ^ rx_byte_q;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q != 2'd3) begin
                        word_d = {rx_byte_q, word_q[23:8]};
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {rx_byte_q, word_q};
                        mem_addr_d  = base_q + {14'd0, word_cnt_q};
                        word_cnt_d  = word_cnt_q + 16'd1;
                        if (word_cnt_q == cnt_q - 16'd1) begin
                            fr_state_d = SUM;
                        end
                    end
                end
                SUM: begin
                    if (rx_byte_q == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    fr_state_d = RESP;
                end
                RESP: ;
                default: fr_state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        tx_start = (fr_state_q == SUM) && rx_valid;
        tx_byte  = (rx_byte_q == csum_q) ? RSP_OK : RSP_BAD;
        busy     = (fr_state_q != HUNT) || tx_active_q;
    end

    // Transmitter: the shift register idles at all ones, so txd is its LSB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_active_q <= 1'b0;
            tx_timer_q  <= 16'd0;
            tx_bit_q    <= 4'd0;
            tx_shift_q  <= 10'h3FF;
        end else begin
            tx_active_q <= tx_active_d;
            tx_timer_q  <= tx_timer_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
        end
    end

    always_comb begin
        tx_active_d = tx_active_q;
        tx_timer_d  = tx_timer_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        if (tx_start) begin
            tx_active_d = 1'b1;
            tx_timer_d  = 16'd0;
            tx_bit_d    = 4'd0;
            tx_shift_d  = {1'b1, tx_byte, 1'b0};
        end else if (tx_active_q) begin
            if (tx_timer_q == BIT_LAST) begin
                tx_timer_d = 16'd0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_active_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_timer_d = tx_timer_q + 16'd1;
            end
        end
    end

    assign tx_done   = tx_active_q && (tx_timer_q == BIT_LAST) && (tx_bit_q == 4'd9);
    assign txd       = tx_shift_q[0];
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of frames with hand-computed writes,
// pulses and response bytes, plus reset, glitch and framing-error sequences.
module tb_uart_loader;

    localparam logic [15:0] P = 16'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic        txd, mem_we, busy, done, err;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    uart_loader #(.PERIOD(P)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Event recorders, written only here.
    logic [29:0] wr_a [256];
    logic [31:0] wr_d [256];
    logic [8:0]  tx_rec [256];
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, tx_cnt = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_a[wr_cnt % 256] = mem_addr;
            wr_d[wr_cnt % 256] = mem_wdata;
            wr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    initial begin : tx_mon
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && txd === 1'b0) begin
                repeat (P / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (P) @(negedge clk);
                    d[i] = txd;
                end
                repeat (P) @(negedge clk);
                tx_rec[tx_cnt % 256] = {txd, d};
                tx_cnt++;
            end
        end
    end

    typedef struct packed {
        logic [19:0][7:0] b;
        int               len;
        int               nwr;
        logic [29:0]      a0;
        logic [31:0]      d0;
        logic [29:0]      a1;
        logic [31:0]      d1;
        int               nd;
        int               ne;
        logic [7:0]       rsp;
    } vec_t;

    vec_t vecs [5];

    task automatic add(input int v, input logic [7:0] x);
        vecs[v].b[vecs[v].len] = x;
        vecs[v].len++;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (P) @(negedge clk);
        end
        rxd = stop;
        repeat (P) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
        repeat (2 * P) @(negedge clk);
    endtask

    task automatic apply_vec(input int v);
        int w0, t0, d0, e0;
        w0 = wr_cnt; t0 = tx_cnt; d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < vecs[v].len; i++) send_byte(vecs[v].b[i], 1'b1);
        wait_idle();
        check($sformatf("v%0d_nwr", v), 64'(wr_cnt - w0), 64'(vecs[v].nwr));
        if (vecs[v].nwr > 0) begin
            check($sformatf("v%0d_a0", v), 64'(wr_a[w0 % 256]), 64'(vecs[v].a0));
            check($sformatf("v%0d_d0", v), 64'(wr_d[w0 % 256]), 64'(vecs[v].d0));
        end
        if (vecs[v].nwr > 1) begin
            check($sformatf("v%0d_a1", v), 64'(wr_a[(w0 + 1) % 256]), 64'(vecs[v].a1));
            check($sformatf("v%0d_d1", v), 64'(wr_d[(w0 + 1) % 256]), 64'(vecs[v].d1));
        end
        check($sformatf("v%0d_done", v), 64'(done_cnt - d0), 64'(vecs[v].nd));
        check($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(vecs[v].ne));
        check($sformatf("v%0d_ntx", v), 64'(tx_cnt - t0), 64'(1));
        check($sformatf("v%0d_rsp", v), 64'(tx_rec[t0 % 256]), 64'({1'b1, vecs[v].rsp}));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, t0, d0, e0, n, busy_seen;
        for (int v = 0; v < 5; v++) vecs[v] = '0;
        // Good two-word frame, checksum 0x38.
        add(0, 8'hA5); add(0, 8'h00); add(0, 8'h10); add(0, 8'h00); add(0, 8'h00);
        add(0, 8'h02); add(0, 8'h00); add(0, 8'h78); add(0, 8'h56); add(0, 8'h34);
        add(0, 8'h12); add(0, 8'hEF); add(0, 8'hBE); add(0, 8'hAD); add(0, 8'hDE);
        add(0, 8'h38);
        vecs[0].nwr = 2; vecs[0].a0 = 30'h400; vecs[0].d0 = 32'h12345678;
        vecs[0].a1 = 30'h401; vecs[0].d1 = 32'hDEADBEEF; vecs[0].nd = 1; vecs[0].rsp = 8'h4B;
        // Same frame, checksum bit 0 flipped.
        for (int i = 0; i < 15; i++) add(1, vecs[0].b[i]);
        add(1, 8'h39);
        vecs[1].nwr = 2; vecs[1].a0 = 30'h400; vecs[1].d0 = 32'h12345678;
        vecs[1].a1 = 30'h401; vecs[1].d1 = 32'hDEADBEEF; vecs[1].ne = 1; vecs[1].rsp = 8'h45;
        // N = 0 frame.
        add(2, 8'hA5);
        for (int i = 0; i < 7; i++) add(2, 8'h00);
        vecs[2].nd = 1; vecs[2].rsp = 8'h4B;
        // Base 0xFFFFFFFC, two words wrap the 30-bit address; checksum 0x89.
        add(3, 8'hA5); add(3, 8'hFC); add(3, 8'hFF); add(3, 8'hFF); add(3, 8'hFF);
        add(3, 8'h02); add(3, 8'h00); add(3, 8'h11); add(3, 8'h22); add(3, 8'h33);
        add(3, 8'h44); add(3, 8'h55); add(3, 8'h66); add(3, 8'h77); add(3, 8'h88);
        add(3, 8'h89);
        vecs[3].nwr = 2; vecs[3].a0 = 30'h3FFFFFFF; vecs[3].d0 = 32'h44332211;
        vecs[3].a1 = 30'h0; vecs[3].d1 = 32'h88776655; vecs[3].nd = 1; vecs[3].rsp = 8'h4B;
        // Junk before header, base low bits ignored (0x103 -> word 0x40); checksum 0x03.
        add(4, 8'h00); add(4, 8'hFF); add(4, 8'h5A); add(4, 8'hA5); add(4, 8'h03);
        add(4, 8'h01); add(4, 8'h00); add(4, 8'h00); add(4, 8'h01); add(4, 8'h00);
        add(4, 8'hAA); add(4, 8'hBB); add(4, 8'hCC); add(4, 8'hDD); add(4, 8'h03);
        vecs[4].nwr = 1; vecs[4].a0 = 30'h40; vecs[4].d0 = 32'hDDCCBBAA; vecs[4].nd = 1;
        vecs[4].rsp = 8'h4B;

        // Reset state.
        reset = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 64'(txd), 64'(1));
        check("rst_we", 64'(mem_we), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        reset = 1'b1;
        repeat (2 * P) @(negedge clk);

        for (int v = 0; v < 5; v++) apply_vec(v);

        // Outputs hold the last write while mem_we is low.
        check("hold_we", 64'(mem_we), 64'(0));
        check("hold_addr", 64'(mem_addr), 64'(30'h40));
        check("hold_wdata", 64'(mem_wdata), 64'(32'hDDCCBBAA));

        // Short low glitch: false start, nothing happens.
        e0 = err_cnt; w0 = wr_cnt; busy_seen = 0;
        @(negedge clk); rxd = 1'b0;
        repeat (P / 4) @(negedge clk);
        rxd = 1'b1;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        check("glitch_busy", 64'(busy_seen), 64'(0));
        check("glitch_err", 64'(err_cnt - e0), 64'(0));
        check("glitch_wr", 64'(wr_cnt - w0), 64'(0));

        // Bad stop bit on the third address byte, then a normal frame.
        e0 = err_cnt; t0 = tx_cnt; d0 = done_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (12 * P) @(negedge clk);
        check("ferr_err", 64'(err_cnt - e0), 64'(1));
        check("ferr_tx", 64'(tx_cnt - t0), 64'(0));
        check("ferr_done", 64'(done_cnt - d0), 64'(0));
        check("ferr_busy", 64'(busy), 64'(0));
        apply_vec(0);

        // Reset mid-word: the partial word must never be written.
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        check("midf_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("midf_rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4 * P) @(negedge clk);
        check("midf_wr", 64'(wr_cnt - w0), 64'(0));
        check("midf_done", 64'(done_cnt - d0), 64'(0));

        // Reset during the response: txd high the cycle after the reset edge.
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < vecs[0].len; i++) send_byte(vecs[0].b[i], 1'b1);
        n = 0;
        while (txd !== 1'b0 && n < 20 * P) begin
            @(negedge clk);
            n++;
        end
        check("midtx_started", 64'(txd), 64'(0));
        repeat (3 * P) @(negedge clk);
        check("midtx_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("midtx_txd", 64'(txd), 64'(1));
        check("midtx_rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        repeat (12 * P) @(negedge clk);
        check("midtx_wr", 64'(wr_cnt - w0), 64'(2));
        check("midtx_done", 64'(done_cnt - d0), 64'(1));
        check("midtx_idle_txd", 64'(txd), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
